// File: rtl/xpb_table_gen.sv
// ============================================================================
// Module   : xpb_table_gen
// Function : Runtime XPB table writer. Streams entry[k] = k * 2^BIT_OFFSET mod N
//            as consecutive RAM writes. Optional macro XPB_GEN_FASTPOW_EN makes
//            the power-of-two phase perform two doublings per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xpb_table_gen #(
    parameter int WIDTH      = 1024,
    parameter int IDX_BITS   = 5,
    parameter int BIT_OFFSET = 530
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    modulus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                wr_en,
    output logic [IDX_BITS-1:0] wr_addr,
    output logic [WIDTH-1:0]    wr_data
);

    localparam int CNT_W = $clog2(BIT_OFFSET + 1) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_POW  = 2'd1;
    localparam logic [1:0] S_GEN  = 2'd2;

    localparam logic [CNT_W-1:0]    C_OFFSET = CNT_W'(BIT_OFFSET);
    localparam logic [IDX_BITS-1:0] C_LAST   = '1;

    logic [1:0]          r_state;
    logic [WIDTH-1:0]    r_mod;
    logic [WIDTH-1:0]    r_acc;
    logic [WIDTH-1:0]    r_base;
    logic [WIDTH-1:0]    r_entry;
    logic [IDX_BITS-1:0] r_k;
    logic [CNT_W-1:0]    r_rem;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_wr_en;
    logic [IDX_BITS-1:0] r_wr_addr;
    logic [WIDTH-1:0]    r_wr_data;

    logic [WIDTH-1:0]    w_dbl1;
    logic [WIDTH-1:0]    w_acc_nxt;
    logic [CNT_W-1:0]    w_rem_nxt;
    logic                w_pow_last;
    logic [WIDTH-1:0]    w_entry_nxt;
    logic                w_mod_ok;

    // One extra bit keeps the carry of 2*a or a+b; inputs are always < n.
    function automatic logic [WIDTH-1:0] f_dbl_mod(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] n);
        logic [WIDTH:0] t;
        t = {a, 1'b0};
        if (t >= {1'b0, n})
            t = t - {1'b0, n};
        return t[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] f_add_mod(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [WIDTH-1:0] n);
        logic [WIDTH:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (t >= {1'b0, n})
            t = t - {1'b0, n};
        return t[WIDTH-1:0];
    endfunction

    assign w_mod_ok    = modulus[0] & (|modulus[WIDTH-1:1]);
    assign w_dbl1      = f_dbl_mod(r_acc, r_mod);
    assign w_entry_nxt = f_add_mod(r_entry, r_base, r_mod);

`ifdef XPB_GEN_FASTPOW_EN
    logic [WIDTH-1:0] w_dbl2;
    logic             w_two;

    // Odd BIT_OFFSET leaves one remaining doubling for the final POW cycle.
    assign w_dbl2     = f_dbl_mod(w_dbl1, r_mod);
    assign w_two      = (r_rem >= CNT_W'(2));
    assign w_acc_nxt  = w_two ? w_dbl2 : w_dbl1;
    assign w_rem_nxt  = r_rem - (w_two ? CNT_W'(2) : CNT_W'(1));
    assign w_pow_last = (r_rem <= CNT_W'(2));
`else
    assign w_acc_nxt  = w_dbl1;
    assign w_rem_nxt  = r_rem - CNT_W'(1);
    assign w_pow_last = (r_rem == CNT_W'(1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mod     <= '0;
            r_acc     <= '0;
            r_base    <= '0;
            r_entry   <= '0;
            r_k       <= '0;
            r_rem     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_mod_ok) begin
                            r_mod   <= modulus;
                            r_acc   <= WIDTH'(1);
                            r_rem   <= C_OFFSET;
                            r_busy  <= 1'b1;
                            r_state <= S_POW;
                        end else begin
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_POW: begin
                    r_acc <= w_acc_nxt;
                    r_rem <= w_rem_nxt;
                    if (w_pow_last) begin
                        r_base  <= w_acc_nxt;
                        r_entry <= '0;
                        r_k     <= '0;
                        r_state <= S_GEN;
                    end
                end
                S_GEN: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_k;
                    r_wr_data <= r_entry;
                    r_entry   <= w_entry_nxt;
                    r_k       <= r_k + IDX_BITS'(1);
                    // Leaving on the last write lets a new start land in the done cycle.
                    if (r_k == C_LAST) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_xpb_table_gen.sv
// ============================================================================
// Module   : tb_xpb_table_gen
// Function : Scoreboard bench for xpb_table_gen (small 16-bit and default-size instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xpb_table_gen;

    localparam int SW = 16;
    localparam int SI = 3;
    localparam int SO = 4;
    localparam int BW = 1024;
    localparam int BI = 5;
    localparam int BO = 530;
`ifdef XPB_GEN_FASTPOW_EN
    localparam int S_POWC = (SO + 1) / 2;
    localparam int B_POWC = (BO + 1) / 2;
`else
    localparam int S_POWC = SO;
    localparam int B_POWC = BO;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_start = 1'b0, b_start = 1'b0;
    logic [SW-1:0] s_mod = '0;
    logic [BW-1:0] b_mod = '0;
    logic          s_busy, s_done, s_err, s_wr_en;
    logic [SI-1:0] s_wr_addr;
    logic [SW-1:0] s_wr_data;
    logic          b_busy, b_done, b_err, b_wr_en;
    logic [BI-1:0] b_wr_addr;
    logic [BW-1:0] b_wr_data;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [SI-1:0] a; logic [SW-1:0] d; } s_exp_t;
    typedef struct { logic [BI-1:0] a; logic [BW-1:0] d; } b_exp_t;
    s_exp_t sq[$];
    b_exp_t bq[$];

    always #5 clk = ~clk;

    xpb_table_gen #(.WIDTH(SW), .IDX_BITS(SI), .BIT_OFFSET(SO)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .modulus(s_mod),
        .busy(s_busy), .done(s_done), .err(s_err),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data));

    xpb_table_gen #(.WIDTH(BW), .IDX_BITS(BI), .BIT_OFFSET(BO)) u_big (
        .clk(clk), .rst(rst), .start(b_start), .modulus(b_mod),
        .busy(b_busy), .done(b_done), .err(b_err),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: every write strobe must match the head of its scoreboard queue.
    always @(negedge clk) begin
        if (s_wr_en === 1'b1) begin
            if (sq.size() == 0) begin
                chk("s_unexpected_write", {125'd0, s_wr_addr}, 128'hDEAD);
            end else begin
                s_exp_t e;
                e = sq.pop_front();
                chk("s_wr_addr", {125'd0, s_wr_addr}, {125'd0, e.a});
                chk("s_wr_data", {112'd0, s_wr_data}, {112'd0, e.d});
            end
        end
    end

    always @(negedge clk) begin
        if (b_wr_en === 1'b1) begin
            if (bq.size() == 0) begin
                chk("b_unexpected_write", {123'd0, b_wr_addr}, 128'hDEAD);
            end else begin
                b_exp_t e;
                e = bq.pop_front();
                chk("b_wr_addr", {123'd0, b_wr_addr}, {123'd0, e.a});
                checks++;
                if (b_wr_data !== e.d) begin
                    errors++;
                    $display("FAIL b_wr_data[%0d]: got ..%h expected ..%h", e.a,
                             b_wr_data[127:0], e.d[127:0]);
                end
            end
        end
    end

    task automatic push_small(input logic [SW-1:0] v [8]);
        for (int i = 0; i < 8; i++) sq.push_back('{a: SI'(i), d: v[i]});
    endtask

    // Runs one small-table generation and checks its timing and handshake.
    task automatic run_small(input logic [SW-1:0] n, input bit mid_start);
        int cyc, nb, first;
        bit done_seen, done_busy;
        @(negedge clk);
        s_mod = n; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0; s_mod = 16'hFFFF;
        cyc = 0; nb = 0; first = -1; done_seen = 0; done_busy = 1;
        for (int g = 0; g < 200; g++) begin
            if (s_busy) nb++;
            if (s_wr_en && first < 0) first = cyc;
            if (s_done) begin done_seen = 1; done_busy = s_busy; break; end
            s_start = mid_start && (cyc == 3);
            @(posedge clk); #1; cyc++;
        end
        s_start = 1'b0;
        chk("s_first_write_latency", 128'(first), 128'(S_POWC + 1));
        chk("s_busy_cycles", 128'(nb), 128'(S_POWC + 8));
        chk("s_done_seen", {127'd0, done_seen}, 128'd1);
        chk("s_busy_low_at_done", {127'd0, done_busy}, 128'd0);
        repeat (2) @(posedge clk);
        #1 chk("s_queue_drained", 128'(sq.size()), 128'd0);
    endtask

    task automatic run_err(input logic [SW-1:0] n);
        bit bad;
        @(negedge clk);
        s_mod = n; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        chk("err_pulse", {127'd0, s_err}, 128'd1);
        chk("err_busy", {127'd0, s_busy}, 128'd0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (s_err || s_busy || s_wr_en) bad = 1;
        end
        chk("err_single_no_activity", {127'd0, bad}, 128'd0);
    endtask

    initial begin
        logic [SW-1:0] t13 [8] = '{16'd0, 16'd3, 16'd6, 16'd9, 16'd12, 16'd2, 16'd5, 16'd8};
        logic [SW-1:0] t11 [8] = '{16'd0, 16'd5, 16'd10, 16'd4, 16'd9, 16'd3, 16'd8, 16'd2};
        logic [1599:0] t, nw;
        int cyc, nb, first;
        bit done_seen, bad;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {127'd0, s_busy}, 128'd0);
        chk("rst_wr_en", {127'd0, s_wr_en}, 128'd0);
        chk("rst_done_err", {126'd0, s_done, s_err}, 128'd0);
        chk("rst_wr_data", {112'd0, s_wr_data}, 128'd0);
        rst = 1'b0;

        push_small(t13); run_small(16'd13, 1'b0);
        push_small(t11); run_small(16'd11, 1'b0);
        run_err(16'd12);
        run_err(16'd1);
        push_small(t13); run_small(16'd13, 1'b1);

        // Reset at the third write, then a clean rerun.
        push_small(t11);
        @(negedge clk);
        s_mod = 16'd11; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int g = 0; g < 100; g++) begin
            if (s_wr_en && s_wr_addr == 3'd2) break;
            @(posedge clk); #1;
        end
        chk("rst_at_third_write_reached", {127'd0, s_wr_en}, 128'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sq.delete();
        chk("midrst_outputs", {110'd0, s_busy, s_done, s_err, s_wr_en, s_wr_addr, s_wr_data[9:0]}, 128'd0);
        chk("midrst_wr_data", {112'd0, s_wr_data}, 128'd0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (s_busy || s_done || s_wr_en) bad = 1;
        end
        chk("midrst_quiet", {127'd0, bad}, 128'd0);
        push_small(t13); run_small(16'd13, 1'b0);

        // Default-size instance with a random odd full-width modulus.
        for (int w = 0; w < BW / 32; w++) b_mod[w*32 +: 32] = $urandom;
        b_mod[0] = 1'b1; b_mod[BW-1] = 1'b1;
        nw = 1600'(b_mod);
        for (int k = 0; k < 32; k++) begin
            t = 1600'(k);
            t = t << BO;
            t = t % nw;
            bq.push_back('{a: BI'(k), d: t[BW-1:0]});
        end
        @(negedge clk);
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        b_mod = '0;
        cyc = 0; nb = 0; first = -1; done_seen = 0;
        for (int g = 0; g < 800; g++) begin
            if (b_busy) nb++;
            if (b_wr_en && first < 0) first = cyc;
            if (b_done) begin done_seen = 1; break; end
            @(posedge clk); #1; cyc++;
        end
        chk("b_first_write_latency", 128'(first), 128'(B_POWC + 1));
        chk("b_busy_cycles", 128'(nb), 128'(B_POWC + 32));
        chk("b_done_seen", {127'd0, done_seen}, 128'd1);
        repeat (2) @(posedge clk);
        #1 chk("b_queue_drained", 128'(bq.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
